// File: rtl/stopwatch_core_pkg.sv
// Shared types and constants for the stopwatch control stage.
// State encodings are fixed so the display path and debug views agree on them.
package stopwatch_core_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_RUN_LAP = 2'd2,
      ST_STOP    = 2'd3
   } sw_state_t;

   localparam int COUNT_W           = 16;
   localparam int DEFAULT_MAX_COUNT = 9999;

   function automatic logic is_running(input sw_state_t s);
      return (s == ST_RUN) || (s == ST_RUN_LAP);
   endfunction

endpackage

// File: rtl/stopwatch_core_btn_conditioner.sv
// One raw push-button to a single-cycle press pulse: 2-flop synchronizer,
// debounce on the synchronized level, rising-edge pulse on accepted presses.
module btn_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic press
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_meta;
   logic             sync_lvl;
   logic             stable_lvl;
   logic [CNT_W-1:0] stable_cnt;

   // stable_cnt counts consecutive cycles the synchronized level disagrees
   // with the accepted level; any agreement (a bounce back) restarts it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_meta  <= 1'b0;
         sync_lvl   <= 1'b0;
         stable_lvl <= 1'b0;
         stable_cnt <= '0;
         press      <= 1'b0;
      end else begin
         sync_meta <= btn_raw;
         sync_lvl  <= sync_meta;
         press     <= 1'b0;
         if (sync_lvl == stable_lvl) begin
            stable_cnt <= '0;
         end else if (stable_cnt == CNT_LAST) begin
            stable_lvl <= sync_lvl;
            stable_cnt <= '0;
            press      <= sync_lvl;
         end else begin
            stable_cnt <= stable_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch control: start/stop/lap/clear FSM, 10 ms prescaler, count and
// lap registers, and the registered value presented to the display driver.
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | cleared, count held at 0, waiting for start
// ST_RUN     | counting, display shows live count
// ST_RUN_LAP | counting, display frozen on the lap register
// ST_STOP    | count held; resume unless overflowed, clear to IDLE
module stopwatch_core
   import stopwatch_core_pkg::*;
#(
   parameter int TICK_CYCLES     = 500_000,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int MAX_COUNT       = DEFAULT_MAX_COUNT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_btn_start_stop,
   input  logic               i_btn_lap,
   input  logic               i_btn_clear,
   output logic [COUNT_W-1:0] o_num,
   output logic               o_running,
   output logic               o_lap_active,
   output logic               o_overflow
);

   localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [PRE_W-1:0]   PRE_LAST    = PRE_W'(TICK_CYCLES - 1);
   localparam logic [COUNT_W-1:0] CNT_MAX     = COUNT_W'(MAX_COUNT);
   localparam logic [COUNT_W-1:0] CNT_PRE_MAX = COUNT_W'(MAX_COUNT - 1);

   logic               ss_press;
   logic               lap_press;
   logic               clr_press;
   sw_state_t          state;
   logic [PRE_W-1:0]   presc;
   logic [COUNT_W-1:0] count;
   logic [COUNT_W-1:0] lap_cnt;
   logic               tick;

   btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_ss (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (i_btn_start_stop),
      .press   (ss_press)
   );

   btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_lap (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (i_btn_lap),
      .press   (lap_press)
   );

   btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_clr (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (i_btn_clear),
      .press   (clr_press)
   );

   assign tick = is_running(state) && (presc == PRE_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ST_IDLE;
         presc        <= '0;
         count        <= '0;
         lap_cnt      <= '0;
         o_overflow   <= 1'b0;
         o_running    <= 1'b0;
         o_lap_active <= 1'b0;
      end else begin
         presc <= '0;
         case (state)
            ST_IDLE: begin
               count <= '0;
               if (ss_press) begin
                  state     <= ST_RUN;
                  o_running <= 1'b1;
               end
            end
            ST_RUN, ST_RUN_LAP: begin
               presc <= tick ? '0 : presc + PRE_W'(1);
               // Terminal count overrides every button in the same cycle.
               if (tick && (count == CNT_PRE_MAX)) begin
                  count        <= CNT_MAX;
                  o_overflow   <= 1'b1;
                  state        <= ST_STOP;
                  o_running    <= 1'b0;
                  o_lap_active <= 1'b0;
                  presc        <= '0;
               end else begin
                  if (tick) begin
                     count <= count + COUNT_W'(1);
                  end
                  if (ss_press) begin
                     state        <= ST_STOP;
                     o_running    <= 1'b0;
                     o_lap_active <= 1'b0;
                     presc        <= '0;
                  end else if (lap_press) begin
                     if (state == ST_RUN) begin
                        lap_cnt      <= count;
                        state        <= ST_RUN_LAP;
                        o_lap_active <= 1'b1;
                     end else begin
                        state        <= ST_RUN;
                        o_lap_active <= 1'b0;
                     end
                  end
               end
            end
            ST_STOP: begin
               if (clr_press) begin
                  state      <= ST_IDLE;
                  count      <= '0;
                  o_overflow <= 1'b0;
               end else if (ss_press && !o_overflow) begin
                  state     <= ST_RUN;
                  o_running <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Display register lags the count/lap/state registers by one cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         o_num <= '0;
      end else begin
         o_num <= (state == ST_RUN_LAP) ? lap_cnt : count;
      end
   end

endmodule

// File: tb/tb_stopwatch_core.sv
// Randomized bench for stopwatch_core against a behavioural reference model.
module tb_stopwatch_core;

   localparam int TICK = 4;
   localparam int DEB  = 3;
   localparam int MAXC = 12;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_LAP  = 2;
   localparam int M_STOP = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        b_ss = 1'b0;
   logic        b_lap = 1'b0;
   logic        b_clr = 1'b0;
   logic [15:0] o_num;
   logic        o_running;
   logic        o_lap_active;
   logic        o_overflow;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   stopwatch_core #(
      .TICK_CYCLES     (TICK),
      .DEBOUNCE_CYCLES (DEB),
      .MAX_COUNT       (MAXC)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .i_btn_start_stop (b_ss),
      .i_btn_lap        (b_lap),
      .i_btn_clear      (b_clr),
      .o_num            (o_num),
      .o_running        (o_running),
      .o_lap_active     (o_lap_active),
      .o_overflow       (o_overflow)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model state
   int m_state, m_cnt, m_lapv, m_since_tick, m_ovf;
   int m_num, m_run, m_lapact;
   int s1[3], s2[3], acc[3], last_v[3], same_len[3], pulse[3];

   task automatic model_reset();
      m_state = M_IDLE; m_cnt = 0; m_lapv = 0; m_since_tick = 0; m_ovf = 0;
      m_num = 0; m_run = 0; m_lapact = 0;
      for (int b = 0; b < 3; b++) begin
         s1[b] = 0; s2[b] = 0; acc[b] = 0; last_v[b] = 0; same_len[b] = 0; pulse[b] = 0;
      end
   endtask

   task automatic model_step();
      int raw[3];
      int ss, lp, cl, tick, was_running, nst;
      raw[0] = int'(b_ss); raw[1] = int'(b_lap); raw[2] = int'(b_clr);
      ss = pulse[0]; lp = pulse[1]; cl = pulse[2];
      m_num = (m_state == M_LAP) ? m_lapv : m_cnt;
      was_running = (m_state == M_RUN || m_state == M_LAP);
      // A tick is due every TICK cycles of uninterrupted running.
      tick = was_running && (m_since_tick == TICK - 1);
      nst = m_state;
      case (m_state)
         M_IDLE: if (ss != 0) nst = M_RUN;
         M_RUN, M_LAP: begin
            if (tick != 0 && m_cnt + 1 == MAXC) begin
               m_cnt = MAXC; m_ovf = 1; nst = M_STOP;
            end else begin
               if (tick != 0) m_cnt = m_cnt + 1;
               if (ss != 0) nst = M_STOP;
               else if (lp != 0) begin
                  if (m_state == M_RUN) begin
                     m_lapv = (tick != 0) ? m_cnt - 1 : m_cnt;
                     nst = M_LAP;
                  end else nst = M_RUN;
               end
            end
         end
         default: begin
            if (cl != 0) begin nst = M_IDLE; m_cnt = 0; m_ovf = 0; end
            else if (ss != 0 && m_ovf == 0) nst = M_RUN;
         end
      endcase
      if (was_running && (nst == M_RUN || nst == M_LAP) && tick == 0)
         m_since_tick = m_since_tick + 1;
      else
         m_since_tick = 0;
      m_state  = nst;
      m_run    = (nst == M_RUN || nst == M_LAP);
      m_lapact = (nst == M_LAP);
      // Buttons: a synchronized level that has held a new value for DEB
      // consecutive samples is accepted; acceptance of a 1 is a press.
      for (int b = 0; b < 3; b++) begin
         pulse[b] = 0;
         if (s2[b] == last_v[b]) begin
            if (same_len[b] < DEB) same_len[b] = same_len[b] + 1;
         end else begin
            same_len[b] = 1;
         end
         last_v[b] = s2[b];
         if (s2[b] != acc[b] && same_len[b] >= DEB) begin
            acc[b] = s2[b];
            pulse[b] = s2[b];
         end
         s2[b] = s1[b];
         s1[b] = raw[b];
      end
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) model_reset();
      else model_step();
   end

   always @(negedge clk) begin
      check("num", 32'(o_num), 32'(m_num));
      check("running", 32'(o_running), 32'(m_run));
      check("lap_active", 32'(o_lap_active), 32'(m_lapact));
      check("overflow", 32'(o_overflow), 32'(m_ovf));
   end

   // mask bit0 = start_stop, bit1 = lap, bit2 = clear
   task automatic press(input logic [2:0] mask, input int hold);
      @(negedge clk);
      b_ss = mask[0]; b_lap = mask[1]; b_clr = mask[2];
      repeat (hold) @(negedge clk);
      b_ss = 1'b0; b_lap = 1'b0; b_clr = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic async_reset();
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("rst_num", 32'(o_num), 32'd0);
      check("rst_running", 32'(o_running), 32'd0);
      check("rst_lap_active", 32'(o_lap_active), 32'd0);
      check("rst_overflow", 32'(o_overflow), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      model_reset();
      idle(3);
      rst = 1'b1;
      idle(2);
      // 2-cycle glitches on start_stop: never accepted
      press(3'b001, 2); idle(3);
      press(3'b001, 2); idle(10);
      // start, run 40 cycles, stop, hold in STOP
      press(3'b001, 6); idle(40);
      press(3'b001, 6); idle(15);
      // resume, lap freeze, lap release, stop, clear
      press(3'b001, 6); idle(12);
      press(3'b010, 6); idle(20);
      press(3'b010, 6); idle(10);
      press(3'b001, 6); idle(5);
      press(3'b100, 6); idle(10);
      // clear ignored in RUN, run to terminal count, start ignored, clear
      press(3'b001, 6); idle(8);
      press(3'b100, 6); idle(60);
      press(3'b001, 6); idle(10);
      press(3'b100, 6); idle(10);
      // lap and start_stop pressed together in RUN
      press(3'b001, 6); idle(10);
      press(3'b011, 6); idle(10);
      press(3'b100, 6); idle(5);
      // reset mid-run, then a normal start
      press(3'b001, 6); idle(15);
      async_reset();
      press(3'b001, 6); idle(20);
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 39) == 0) async_reset();
         press(3'($urandom_range(1, 7)), int'($urandom_range(1, 7)));
         idle(int'($urandom_range(0, 25)));
      end
      idle(5);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
